// File: rtl/simple_bus_pkg.sv
// Shared types for the simple strobe/ready/busx bus: FSM states, legal access
// size and the latched request record used by bus-side blocks.
package simple_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] DSIZE_32 = 2'd2;

    typedef struct packed {
        logic [63:0] address;
        logic [1:0]  dsize;
        logic        readins;
        logic        readmem;
        logic        writemem;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic logic multi_strobe(input bus_req_t r);
        return (r.readins & r.readmem) | (r.readins & r.writemem) | (r.readmem & r.writemem);
    endfunction

endpackage

// File: rtl/mem_bus_grant.sv
// Two-way grant pick. Fixed priority (port 0 wins) by default; round-robin on
// ties when MEM_BUS_ARB_ROUND_ROBIN_EN is defined.
module mem_bus_grant (
    input  logic req0_i,
    input  logic req1_i,
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    input  logic last_gnt_i,
`endif
    output logic gnt_o
);

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    // On a tie the port granted last yields; a lone requester always wins.
    assign gnt_o = (req0_i && req1_i) ? ~last_gnt_i : req1_i;
`else
    assign gnt_o = req1_i & ~req0_i;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter/sequencer for the single-port word RAM with fault checking.
// Optional round-robin arbitration: define MEM_BUS_ARB_ROUND_ROBIN_EN.
module mem_bus_arbiter
    import simple_bus_pkg::*;
#(
    parameter int RAM_WORDS = 8191,
    parameter int RAM_AW    = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [63:0]       m0_address,
    input  logic [1:0]        m0_dsize,
    input  logic              m0_readins,
    input  logic              m0_readmem,
    input  logic              m0_writemem,
    input  logic [63:0]       m0_dout,
    output logic [63:0]       m0_din,
    output logic              m0_ready,
    output logic              m0_busx,
    input  logic [63:0]       m1_address,
    input  logic [1:0]        m1_dsize,
    input  logic              m1_readins,
    input  logic              m1_readmem,
    input  logic              m1_writemem,
    input  logic [63:0]       m1_dout,
    output logic [63:0]       m1_din,
    output logic              m1_ready,
    output logic              m1_busx,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [63:0] ADDR_LIMIT = 64'(RAM_WORDS) << 2;

    state_e      state_q, state_d;
    bus_req_t    req_q, req_d;
    logic        gnt_q, gnt_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  busx_q, busx_d;
    logic [63:0] din0_q, din0_d;
    logic [63:0] din1_q, din1_d;

    bus_req_t    m0_req, m1_req;
    logic        req0, req1, gnt_sel, fault;
    logic        unused_dout_hi;

    assign m0_req = '{address: m0_address, dsize: m0_dsize, readins: m0_readins,
                      readmem: m0_readmem, writemem: m0_writemem, wdata: m0_dout[31:0]};
    assign m1_req = '{address: m1_address, dsize: m1_dsize, readins: m1_readins,
                      readmem: m1_readmem, writemem: m1_writemem, wdata: m1_dout[31:0]};
    assign req0   = m0_readins | m0_readmem | m0_writemem;
    assign req1   = m1_readins | m1_readmem | m1_writemem;

    // Only the low word of write data is ever stored.
    assign unused_dout_hi = ^{m0_dout[63:32], m1_dout[63:32]};

    mem_bus_grant u_grant (
        .req0_i     (req0),
        .req1_i     (req1),
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
        .last_gnt_i (gnt_q),
`endif
        .gnt_o      (gnt_sel)
    );

    // The latched request is frozen from grant to response, so evaluating the
    // fault rules on it is equivalent to evaluating them at the grant edge.
    assign fault = multi_strobe(req_q)
                || (req_q.address >= ADDR_LIMIT)
                || (req_q.address[1:0] != 2'b00)
                || (req_q.dsize != DSIZE_32);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        gnt_d   = gnt_q;
        ready_d = '0;
        busx_d  = '0;
        din0_d  = din0_q;
        din1_d  = din1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = gnt_sel;
                    req_d   = gnt_sel ? m1_req : m0_req;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                state_d = ST_IDLE;
                if (fault) begin
                    busx_d[gnt_q] = 1'b1;
                end else begin
                    ready_d[gnt_q] = 1'b1;
                    if (!req_q.writemem) begin
                        if (gnt_q) din1_d = {32'h0, ram_rdata};
                        else       din0_d = {32'h0, ram_rdata};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM strobes are decoded straight from state so reset removes them at once.
    always_comb begin
        ram_addr  = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (state_q == ST_ACCESS && !fault) begin
            ram_addr = req_q.address[RAM_AW+1:2];
            if (req_q.writemem) begin
                ram_we    = 1'b1;
                ram_wdata = req_q.wdata;
            end else begin
                ram_re = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            gnt_q   <= 1'b1;
            ready_q <= '0;
            busx_q  <= '0;
            din0_q  <= '0;
            din1_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            gnt_q   <= gnt_d;
            ready_q <= ready_d;
            busx_q  <= busx_d;
            din0_q  <= din0_d;
            din1_q  <= din1_d;
        end
    end

    assign m0_ready = ready_q[0];
    assign m1_ready = ready_q[1];
    assign m0_busx  = busx_q[0];
    assign m1_busx  = busx_q[1];
    assign m0_din   = din0_q;
    assign m1_din   = din1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural RAM model; tie and
// starvation expectations follow MEM_BUS_ARB_ROUND_ROBIN_EN.
module tb_mem_bus_arbiter;

    localparam int RAM_WORDS = 8191;
    localparam int RAM_AW    = 13;
    localparam logic [2:0] S_NONE = 3'b000;
    localparam logic [2:0] S_INS  = 3'b100;
    localparam logic [2:0] S_MEM  = 3'b010;
    localparam logic [2:0] S_WR   = 3'b001;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [63:0]       m0_address, m1_address, m0_dout, m1_dout, m0_din, m1_din;
    logic [1:0]        m0_dsize, m1_dsize;
    logic              m0_readins, m0_readmem, m0_writemem, m0_ready, m0_busx;
    logic              m1_readins, m1_readmem, m1_writemem, m1_ready, m1_busx;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_re, ram_we;
    logic [31:0]       ram_wdata, ram_rdata;
    logic [31:0]       mem [RAM_WORDS];

    int checks = 0;
    int failures = 0;

    int              resp_first [2];
    int              resp_last  [2];
    int              pulses     [2];
    logic            got_ready  [2];
    logic            got_busx   [2];
    logic [63:0]     got_din    [2];
    logic            pend       [2];
    int              reissue0;
    int              n_re, n_we;
    logic [RAM_AW-1:0] last_addr;
    logic [31:0]     last_wdata;

    mem_bus_arbiter #(.RAM_WORDS(RAM_WORDS), .RAM_AW(RAM_AW)) dut (
        .clock(clock), .reset(reset),
        .m0_address(m0_address), .m0_dsize(m0_dsize), .m0_readins(m0_readins),
        .m0_readmem(m0_readmem), .m0_writemem(m0_writemem), .m0_dout(m0_dout),
        .m0_din(m0_din), .m0_ready(m0_ready), .m0_busx(m0_busx),
        .m1_address(m1_address), .m1_dsize(m1_dsize), .m1_readins(m1_readins),
        .m1_readmem(m1_readmem), .m1_writemem(m1_writemem), .m1_dout(m1_dout),
        .m1_din(m1_din), .m1_ready(m1_ready), .m1_busx(m1_busx),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [2:0] strb, input logic [63:0] addr,
                            input logic [1:0] ds, input logic [63:0] data);
        if (p == 0) begin
            {m0_readins, m0_readmem, m0_writemem} = strb;
            m0_address = addr; m0_dsize = ds; m0_dout = data;
        end else begin
            {m1_readins, m1_readmem, m1_writemem} = strb;
            m1_address = addr; m1_dsize = ds; m1_dout = data;
        end
    endtask

    task automatic sample(input int t);
        if (ram_re) begin n_re++; last_addr = ram_addr; end
        if (ram_we) begin n_we++; last_addr = ram_addr; last_wdata = ram_wdata; end
        for (int p = 0; p < 2; p++) begin
            logic r, b;
            r = (p == 0) ? m0_ready : m1_ready;
            b = (p == 0) ? m0_busx  : m1_busx;
            if (r || b) begin
                pulses[p]++;
                got_ready[p] = got_ready[p] | r;
                got_busx[p]  = got_busx[p] | b;
                got_din[p]   = (p == 0) ? m0_din : m1_din;
                if (resp_first[p] < 0) resp_first[p] = t;
                resp_last[p] = t;
                if (pend[p]) begin
                    if (p == 0 && reissue0 > 0) reissue0--;
                    else begin
                        pend[p] = 1'b0;
                        set_port(p, S_NONE, 64'h0, 2'd2, 64'h0);
                    end
                end
            end
        end
    endtask

    // Ticks until every pending port has responded, then one more cycle so
    // over-long pulses show up in the pulse count.
    task automatic wait_resp(input int budget);
        int t;
        t = 0;
        n_re = 0; n_we = 0; last_addr = '0; last_wdata = '0;
        for (int p = 0; p < 2; p++) begin
            resp_first[p] = -1; resp_last[p] = -1; pulses[p] = 0;
            got_ready[p] = 1'b0; got_busx[p] = 1'b0; got_din[p] = '0;
        end
        while ((pend[0] || pend[1]) && t < budget) begin
            @(posedge clock); #1; t++;
            sample(t);
        end
        if (pend[0] || pend[1]) begin
            check("timeout", {62'h0, pend[1], pend[0]}, 64'h0);
            pend[0] = 1'b0; pend[1] = 1'b0; reissue0 = 0;
            set_port(0, S_NONE, 64'h0, 2'd2, 64'h0);
            set_port(1, S_NONE, 64'h0, 2'd2, 64'h0);
            repeat (4) @(posedge clock);
            #1;
        end else begin
            @(posedge clock); #1; t++;
            sample(t);
        end
    endtask

    task automatic single(input int p, input logic [2:0] strb, input logic [63:0] addr,
                          input logic [1:0] ds, input logic [63:0] data);
        set_port(p, strb, addr, ds, data);
        pend[p] = 1'b1;
        wait_resp(20);
    endtask

    logic [63:0] flt_addr [3];
    logic [1:0]  flt_ds   [3];
    int          idle_pulses;

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0; reissue0 = 0;
        set_port(0, S_NONE, 64'h0, 2'd2, 64'h0);
        set_port(1, S_NONE, 64'h0, 2'd2, 64'h0);
        flt_addr[0] = 64'h2;    flt_ds[0] = 2'd2;
        flt_addr[1] = 64'h7FFC; flt_ds[1] = 2'd2;
        flt_addr[2] = 64'h8;    flt_ds[2] = 2'd3;

        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", {62'h0, m1_ready, m0_ready}, 64'h0);
        check("rst_busx",  {62'h0, m1_busx, m0_busx}, 64'h0);
        check("rst_din",   m0_din | m1_din, 64'h0);
        check("rst_ram_en", {62'h0, ram_re, ram_we}, 64'h0);
        reset = 1'b1;

        // Port 0 write then read at byte address 12.
        single(0, S_WR, 64'd12, 2'd2, 64'hFFFF_FFFF_0000_0008);
        check("w12_lat",   64'(resp_first[0]), 64'd3);
        check("w12_ready", {63'h0, got_ready[0]}, 64'h1);
        check("w12_busx",  {63'h0, got_busx[0]}, 64'h0);
        check("w12_we",    64'(n_we), 64'd1);
        check("w12_addr",  64'(last_addr), 64'd3);
        check("w12_data",  64'(last_wdata), 64'h8);
        check("w12_pulse", 64'(pulses[0]), 64'd1);
        check("w12_other", 64'(pulses[1]), 64'd0);
        single(0, S_INS, 64'd12, 2'd2, 64'h0);
        check("r12_lat",   64'(resp_first[0]), 64'd3);
        check("r12_din",   got_din[0], 64'h0000_0000_0000_0008);
        check("r12_re",    64'(n_re), 64'd1);
        check("r12_addr",  64'(last_addr), 64'd3);

        // Highest legal word.
        single(0, S_WR, 64'h7FF8, 2'd2, 64'hDEAD_BEEF_A5A5_1234);
        check("wtop_addr", 64'(last_addr), 64'h1FFE);
        single(0, S_MEM, 64'h7FF8, 2'd2, 64'h0);
        check("rtop_din",  got_din[0], 64'h0000_0000_A5A5_1234);
        check("rtop_hold", m0_din, 64'h0000_0000_A5A5_1234);

        // Multiple strobes fault and must not write.
        single(0, S_WR, 64'd16, 2'd2, 64'h55);
        single(0, S_MEM | S_WR, 64'd16, 2'd2, 64'h99);
        check("multi_busx",  {63'h0, got_busx[0]}, 64'h1);
        check("multi_ready", {63'h0, got_ready[0]}, 64'h0);
        check("multi_ram",   64'(n_we + n_re), 64'd0);
        check("multi_lat",   64'(resp_first[0]), 64'd3);
        single(0, S_INS, 64'd16, 2'd2, 64'h0);
        check("multi_keep",  got_din[0], 64'h55);

        // Port 1 faults: misaligned, out of range, bad size.
        for (int i = 0; i < 3; i++) begin
            single(1, S_MEM, flt_addr[i], flt_ds[i], 64'h0);
            check($sformatf("flt%0d_busx", i),  {63'h0, got_busx[1]}, 64'h1);
            check($sformatf("flt%0d_ready", i), {63'h0, got_ready[1]}, 64'h0);
            check($sformatf("flt%0d_pulse", i), 64'(pulses[1]), 64'd1);
            check($sformatf("flt%0d_ram", i),   64'(n_re + n_we), 64'd0);
            check($sformatf("flt%0d_din", i),   m1_din, 64'h0);
            check($sformatf("flt%0d_other", i), 64'(pulses[0]), 64'd0);
        end

        // Preload through port 1; writes leave its din untouched.
        single(1, S_WR, 64'd0, 2'd2, 64'h11);
        single(1, S_WR, 64'd4, 2'd2, 64'h22);
        single(1, S_WR, 64'd20, 2'd2, 64'h33);
        check("p1w_ready", {63'h0, got_ready[1]}, 64'h1);
        check("p1w_din",   m1_din, 64'h0);

        // Simultaneous reads: port 0 wins the first tie in both builds.
        set_port(0, S_MEM, 64'd0, 2'd2, 64'h0);
        set_port(1, S_INS, 64'd4, 2'd2, 64'h0);
        pend[0] = 1'b1; pend[1] = 1'b1;
        wait_resp(30);
        check("tie_p0_lat", 64'(resp_first[0]), 64'd3);
        check("tie_p1_lat", 64'(resp_first[1]), 64'd6);
        check("tie_p0_din", got_din[0], 64'h11);
        check("tie_p1_din", got_din[1], 64'h22);
        check("tie_re",     64'(n_re), 64'd2);

        // Port 0 back-to-back (11 reads) against a waiting port 1.
        set_port(0, S_MEM, 64'd0, 2'd2, 64'h0);
        set_port(1, S_MEM, 64'd4, 2'd2, 64'h0);
        reissue0 = 10;
        pend[0] = 1'b1; pend[1] = 1'b1;
        wait_resp(60);
        check("b2b_p0_pulses", 64'(pulses[0]), 64'd11);
        check("b2b_p1_din",    got_din[1], 64'h22);
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
        check("b2b_p1_lat",    64'(resp_first[1]), 64'd6);
        check("b2b_p0_last",   64'(resp_last[0]), 64'd36);
`else
        check("b2b_p1_lat",    64'(resp_first[1]), 64'd36);
        check("b2b_p0_last",   64'(resp_last[0]), 64'd33);
`endif

        // Reset during the ACCESS cycle of a write.
        set_port(0, S_WR, 64'd20, 2'd2, 64'h77);
        @(posedge clock); #1;
        check("rmw_we_pre",   {63'h0, ram_we}, 64'h1);
        check("rmw_addr_pre", 64'(ram_addr), 64'd5);
        #2 reset = 1'b0;
        #1;
        check("rmw_we_async", {63'h0, ram_we}, 64'h0);
        check("rmw_outs",     {60'h0, m0_ready, m0_busx, m1_ready, m1_busx}, 64'h0);
        check("rmw_din",      m0_din, 64'h0);
        set_port(0, S_NONE, 64'h0, 2'd2, 64'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        idle_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (m0_ready || m0_busx || ram_we || ram_re) idle_pulses++;
        end
        check("rmw_no_resp", 64'(idle_pulses), 64'd0);
        single(0, S_INS, 64'd20, 2'd2, 64'h0);
        check("rmw_not_written", got_din[0], 64'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
